// File: rtl/uart_tx_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// uart_tx_arbiter: packet-level round-robin sharing of one uart_tx serializer.
// Define UART_ARB_CHANNEL_TAG_EN to prefix every grant with tag byte {4'hA, idx}.
// Revision: 1.0
//------------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_GAP = 4096,
  parameter int GAP_W   = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 arb_busy,
  output logic                 gap_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    LAUNCH    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] pick;
  logic             pick_found;
  logic [CW-1:0]    cand;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_byte;
  logic [7:0]       own_data;
  logic             own_valid;
  logic             own_last;

  // Walk downward so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (req_valid[cand[IDX_W-1:0]]) begin
        pick       = cand[IDX_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_data  = req_data[i*8 +: 8];
        own_valid = req_valid[i];
        own_last  = req_last[i];
      end
    end
  end

  assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
  assign req_ready  = (state == SEND) ? grant : '0;
  assign arb_busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      last_byte   <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      gap_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      gap_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found && !tx_busy) begin
            owner <= pick;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
`ifdef UART_ARB_CHANNEL_TAG_EN
            tx_data   <= {4'hA, 4'(pick)};
            tx_start  <= 1'b1;
            last_byte <= 1'b0;
            state     <= LAUNCH;
`else
            state     <= SEND;
`endif
          end
        end
        SEND: begin
          if (own_valid) begin
            tx_data   <= own_data;
            tx_start  <= 1'b1;
            last_byte <= own_last;
            gap_cnt   <= '0;
            state     <= LAUNCH;
          end else if (gap_cnt == GAP_W'(MAX_GAP - 1)) begin
            gap_timeout <= 1'b1;
            gap_cnt     <= '0;
            rr_ptr      <= owner_next;
            grant       <= '0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        // uart_tx only raises busy the cycle after tx_start, so skip sampling here.
        LAUNCH: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_byte) begin
              rr_ptr <= owner_next;
              grant  <= '0;
              state  <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer (CLK_FREQ 50 MHz, BAUD_RATE 115200 build) between NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity. A granted requester keeps the transmitter until its byte flagged last has been sent, or until it stalls for longer than MAX_GAP cycles.
- Sits between the command/telemetry sources and uart_tx. Sequences tx_start against tx_busy so that no byte is dropped or overlapped.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_GAP, 4096, cycles a granted requester may hold req_valid low mid-packet before its grant is revoked (>=2).
- GAP_W, 13, width of the gap counter; must satisfy 2^GAP_W > MAX_GAP.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  current byte ends the packet.
- req_ready  out  NUM_REQ  byte accepted when valid&ready; combinational.
- grant  out  NUM_REQ  one-hot current owner, registered; all-zero when no owner.
- tx_data  out  8  byte to uart_tx, registered.
- tx_start  out  1  one-cycle pulse to uart_tx, registered.
- tx_busy  in  1  uart_tx busy; contract: high from the cycle after tx_start until the stop bit completes.
- arb_busy  out  1  high whenever state != IDLE.
- gap_timeout  out  1  one-cycle pulse when a grant is revoked for stalling.

Behaviour:
- Reset values: grant=0, tx_data=0, tx_start=0, req_ready=0, arb_busy=0, gap_timeout=0, rr_ptr=0, FSM=IDLE, gap counter=0.
- Reset applies on any cycle, including mid-frame. A tx_start already issued is not recalled. After reset the FSM re-enters IDLE and waits for tx_busy low before the next launch.
- FSM states: IDLE, SEND, LAUNCH, WAIT_DONE.
- IDLE:
  - If any req_valid is high and tx_busy is low, grant the first valid index at or after rr_ptr, searching upward modulo NUM_REQ. Go to SEND.
  - grant updates on the transition edge.
- SEND:
  - req_ready[g] = 1 only for the granted index g. All other req_ready bits are 0.
  - On valid&ready, register tx_data=byte and tx_start=1, latch last=req_last[g], clear the gap counter, go to LAUNCH.
  - If valid is low, increment the gap counter. When it reaches MAX_GAP, pulse gap_timeout, set rr_ptr=g+1 (mod NUM_REQ), clear grant, go to IDLE.
- LAUNCH: exactly one cycle. tx_start returns to 0. Go to WAIT_DONE; tx_busy is not sampled in this cycle.
- WAIT_DONE:
  - req_ready=0.
  - When tx_busy==0: if last is set, set rr_ptr=g+1 (mod NUM_REQ), clear grant, go to IDLE; otherwise go back to SEND.
- Byte throughput is one byte per uart_tx frame plus 2 cycles of overhead. The minimum from valid in IDLE to tx_start is 2 cycles: grant, then accept.
- Simultaneous requests are resolved only by round-robin order. A requester asserting valid during another requester's packet waits and never sees ready.
- Single-byte packets (last on the first byte) are legal.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Requesters must hold data/last stable while valid is high and ready is low. The arbiter makes no check of this.

Optional Feature:
- Macro: UART_ARB_CHANNEL_TAG_EN.
- Defined:
  - On each grant, the FSM first launches a tag byte {4'hA, 4'(g)} through LAUNCH/WAIT_DONE before entering SEND.
  - req_ready stays 0 during the tag.
  - A gap timeout after the tag still revokes the grant; no trailing byte is sent.
- Not defined: no tag byte; behaviour is as above.

Test Plan:
- Reset, then req0 sends packet {0x11,0x22(last)} with a uart_tx model (busy for 434*10 cycles) -> tx_start pulses carry 0x11 then 0x22; exactly 2 pulses; grant returns to 0; rr_ptr=1.
- req0, req1 and req3 all valid at the same cycle with single-byte packets 0xA5, 0x3C, 0x7E -> serial order is 0xA5, 0x3C, 0x7E; grant sequence 0001, 0010, 1000.
- req2 sends 0x55 (not last), then holds valid low for MAX_GAP cycles -> gap_timeout pulses once; grant is cleared; pending req1 is granted next; no byte is sent after 0x55.
- req1 has valid and tx_busy is forced high in IDLE -> no grant until tx_busy falls; then tx_start fires 2 cycles later.
- rst asserted during WAIT_DONE -> the next cycle shows grant=0, req_ready=0, arb_busy=0; the next packet launches only after tx_busy is low.
- With UART_ARB_CHANNEL_TAG_EN, req3 sends 0x3C(last) -> tx_data sequence is 0xA3, 0x3C.
